sha512_mmio_rd_responder: RTL and testbench
===========================================

SHA512_MMIO_RD_RESPONDER -- requirements
Module: sha512_mmio_rd_responder

Interface
REQ-001 Parameter HC_AFU_DFH, default 64'h1000_0000_0000_0001, value returned at byte 0x000.
REQ-002 Parameter HC_AFU_ID, default 128'h0, {ID_H, ID_L}; ID_L returned at byte 0x008, ID_H at byte 0x010.
REQ-003 Port clk, input, 1, sole clock; one clock, all state on its rising edge.
REQ-004 Port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 Port rx_mmio, input, t_if_ccip_c0_Rx, host MMIO channel; uses mmioRdValid and hdr as t_ccip_c0_ReqMmioHdr (address, length, tid).
REQ-006 Port tx_mmio, output, t_if_ccip_c2_Tx, MMIO read response: mmioRdValid, hdr.tid, data.
REQ-007 Port dsm_base, input, t_hc_address, current DSM base CSR.
REQ-008 Port control, input, t_hc_control, current HC_CONTROL CSR.
REQ-009 Port buffers, input, t_hc_buffer [HC_BUFFER_SIZE], current buffer CSRs.
REQ-010 Port busy, input, 1, hashing core active.
REQ-011 Port done, input, 1, hashing core finished.
REQ-012 Port start_pulse, input, 1, one-cycle pulse on HC_CONTROL_START write.

Function
REQ-013 Byte address = hdr.address << 2; reads with hdr.address >= 'h100 SHALL still be answered, with data 0.
REQ-014 Map: 0x000 DFH; 0x008 ID_L; 0x010 ID_H; 0x018, 0x020 zero; 0x110 dsm_base; 0x118 control zero-extended.
REQ-015 Map: 0x120+0x10*i buffers[i].address; 0x128+0x10*i buffers[i].size zero-extended; i in 0..HC_BUFFER_SIZE-1.
REQ-016 Map: HC_STATUS 0x150 = {62'b0, done, busy}; HC_CYCLES 0x158 = cycle counter; every other address returns 0.
REQ-017 length 2'b01 (8B): return the 64-bit register at the 8B-aligned address.
REQ-018 length 2'b00 (4B): return the addressed dword (hdr.address[0] selects upper or lower half) in data[31:0], upper bits 0.
REQ-019 Fixed latency 2: request sampled in cycle N (stage 1: decode, capture tid/offset); response valid in cycle N+2 (stage 2: mux, register output).
REQ-020 Fully pipelined: one request per cycle accepted; back-to-back reads return in order, one per cycle, each with its own tid.
REQ-021 tx_mmio.mmioRdValid high exactly one cycle per request; data and tid held only while valid, 0 otherwise.
REQ-022 Data is sampled from inputs in stage 1; CSR changes after stage 1 do not affect that response.
REQ-023 Cycle counter, 64 bit: clears to 0 on start_pulse; else +1 while busy; saturates at all ones.
REQ-024 start_pulse and busy in the same cycle: the counter becomes 0 (clear wins).
REQ-025 A read of 0x158 in the cycle the counter updates returns the pre-update value.
REQ-026 mmioWrValid traffic is ignored entirely.

Reset
REQ-027 Asserting reset_n low at any time immediately drives tx_mmio.mmioRdValid = 0, data = 0, tid = 0.
REQ-028 Reset clears both pipeline stages (in-flight reads dropped, no response) and clears the counter to 0.
REQ-029 The first request sampled after reset_n deasserts is answered normally.

Structure
REQ-030 HC_STATUS (16'h150), HC_CYCLES (16'h158), the DFH reserved offsets and the stage-1 pipeline struct type (valid, tid, offset, half select, length) SHALL be added to sha512_pkg.
REQ-031 One sub-module, sha512_busy_counter, SHALL contain the saturating cycle counter.

Verification
REQ-032 8B read at word addr 0x0, tid 0x05 -> two cycles later valid=1, tid 0x05, data = HC_AFU_DFH.
REQ-033 4B reads of 0x110 and 0x114 with dsm_base = 64'hAABB_CCDD_1122_3344 -> data 0x1122_3344, then 0xAABB_CCDD.
REQ-034 Four back-to-back reads (0x008, 0x010, 0x128, 0x400) with tids 1..4 -> four consecutive responses in order: ID_L, ID_H, buffers[0].size, 0.
REQ-035 busy high 10 cycles, then read 0x158 -> 10; start_pulse together with busy -> a later read returns the count from 0; a preload near all ones -> saturation holds.
REQ-036 reset_n pulsed low one cycle after a read -> no response issued; outputs 0 during reset; the next read is answered with latency 2.

Source files
------------

// File: rtl/sha512_pkg.sv
// Shared types and register offsets for the SHA-512 host-control block.
package sha512_pkg;

  localparam int HC_BUFFER_SIZE = 3;

  typedef logic [63:0] t_hc_address;
  typedef logic [31:0] t_hc_control;

  typedef struct packed {
    t_hc_address address;
    logic [31:0] size;
  } t_hc_buffer;

  // Host MMIO request header (word address, length code, transaction id)
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  // Byte offsets of the CSR map
  localparam logic [15:0] HC_DFH           = 16'h000;
  localparam logic [15:0] HC_ID_L          = 16'h008;
  localparam logic [15:0] HC_ID_H          = 16'h010;
  localparam logic [15:0] HC_DFH_RSVD0     = 16'h018;
  localparam logic [15:0] HC_DFH_RSVD1     = 16'h020;
  localparam logic [15:0] HC_DSM_BASE      = 16'h110;
  localparam logic [15:0] HC_CONTROL       = 16'h118;
  localparam logic [15:0] HC_BUFFER_BASE   = 16'h120;
  localparam logic [15:0] HC_STATUS        = 16'h150;
  localparam logic [15:0] HC_CYCLES        = 16'h158;

  // Read pipeline stage 1: request attributes travelling with the sampled data.
  // offset is the 8-byte word index (byte address >> 3).
  typedef struct packed {
    logic        valid;
    logic [8:0]  tid;
    logic [14:0] offset;
    logic        half;
    logic [1:0]  length;
  } t_rd_stage1;

endpackage

// File: rtl/sha512_busy_counter.sv
// Saturating 64-bit count of cycles the hashing core spends busy.
module sha512_busy_counter #(
  parameter logic [63:0] RESET_VALUE = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_pulse,
  input  logic        busy,
  output logic [63:0] count
);

  // Clear on start (wins over busy), else count busy cycles and stick at all ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   count <= RESET_VALUE;
    else if (start_pulse)           count <= '0;
    else if (busy && count != '1)   count <= count + 64'd1;
  end

endmodule

// File: rtl/sha512_mmio_rd_responder.sv
// Two-stage, fully pipelined MMIO read responder for the SHA-512 CSR space.
// Stage 1 snapshots the addressed 64-bit register, stage 2 selects the dword
// for 4-byte reads, applies the range check and registers the response.
module sha512_mmio_rd_responder
  import sha512_pkg::*;
#(
  parameter logic [63:0]  HC_AFU_DFH  = 64'h1000_0000_0000_0001,
  parameter logic [127:0] HC_AFU_ID   = 128'h0,
  // Counter value after reset; left at zero outside of saturation bring-up
  parameter logic [63:0]  CYCLES_INIT = 64'h0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  t_if_ccip_c0_Rx rx_mmio,
  output t_if_ccip_c2_Tx tx_mmio,
  input  t_hc_address    dsm_base,
  input  t_hc_control    control,
  input  t_hc_buffer     buffers [HC_BUFFER_SIZE],
  input  logic           busy,
  input  logic           done,
  input  logic           start_pulse
);

  localparam logic [6:0] BUF_W = HC_BUFFER_BASE[9:3];

  logic [63:0] cycles;
  logic [6:0]  sel;
  logic [63:0] rd_data;
  t_rd_stage1  s1;
  logic [63:0] s1_data;
  logic [63:0] s2_data;
  logic        unused;

  sha512_busy_counter #(.RESET_VALUE(CYCLES_INIT)) u_cnt (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_pulse (start_pulse),
    .busy        (busy),
    .count       (cycles)
  );

  // Only the in-page word index is decoded here; the page check is in stage 2
  assign sel = rx_mmio.hdr.address[7:1];

  // Stage 1 decode: pick the 64-bit register addressed this cycle
  always_comb begin
    rd_data = '0;
    case (sel)
      HC_DFH[9:3]:       rd_data = HC_AFU_DFH;
      HC_ID_L[9:3]:      rd_data = HC_AFU_ID[63:0];
      HC_ID_H[9:3]:      rd_data = HC_AFU_ID[127:64];
      HC_DFH_RSVD0[9:3],
      HC_DFH_RSVD1[9:3]: rd_data = '0;
      HC_DSM_BASE[9:3]:  rd_data = dsm_base;
      HC_CONTROL[9:3]:   rd_data = 64'(control);
      HC_STATUS[9:3]:    rd_data = {62'b0, done, busy};
      HC_CYCLES[9:3]:    rd_data = cycles;
      default:           rd_data = '0;
    endcase
    for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
      if (sel == BUF_W + 7'(2 * i))     rd_data = buffers[i].address;
      if (sel == BUF_W + 7'(2 * i + 1)) rd_data = 64'(buffers[i].size);
    end
  end

  // Stage 1 register: request attributes plus the register snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s1_data <= '0;
    end else begin
      s1.valid  <= rx_mmio.mmioRdValid;
      s1.tid    <= rx_mmio.hdr.tid;
      s1.offset <= rx_mmio.hdr.address[15:1];
      s1.half   <= rx_mmio.hdr.address[0];
      s1.length <= rx_mmio.hdr.length;
      s1_data   <= rd_data;
    end
  end

  // Stage 2 mux: anything beyond the first 1 KB reads as zero; 4B reads take one dword
  always_comb begin
    s2_data = '0;
    if (s1.valid && s1.offset[14:7] == '0) begin
      if (s1.length == 2'b00) s2_data = {32'b0, s1.half ? s1_data[63:32] : s1_data[31:0]};
      else                    s2_data = s1_data;
    end
  end

  // Stage 2 register: response payload is zero whenever valid is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_mmio <= '0;
    end else begin
      tx_mmio.mmioRdValid <= s1.valid;
      tx_mmio.hdr.tid     <= s1.valid ? s1.tid : '0;
      tx_mmio.data        <= s2_data;
    end
  end

  assign unused = ^{rx_mmio.data, rx_mmio.rspValid, rx_mmio.mmioWrValid,
                    rx_mmio.hdr.rsvd, s1.offset[6:0]};

endmodule

// File: tb/tb_sha512_mmio_rd_responder.sv
// Directed bench: a CSR-map model predicts every response; a per-cycle
// compare checks the DUT, and literal values pin the model.
module tb_sha512_mmio_rd_responder;
  import sha512_pkg::*;

  localparam logic [127:0] ID  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [63:0]  DFH = 64'h1000_0000_0000_0001;

  logic           clk = 1'b0;
  logic           reset_n;
  t_if_ccip_c0_Rx rx;
  t_if_ccip_c2_Tx tx, tx_sat;
  t_hc_address    dsm_base;
  t_hc_control    control;
  t_hc_buffer     buffers [HC_BUFFER_SIZE];
  logic           busy, done, start_pulse, busy_sat, start_sat;

  typedef struct {
    int          due;
    logic [8:0]  tid;
    logic [63:0] data;
    bit          has_lit;
    logic [63:0] lit;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mcnt = '0;

  always #5 clk = ~clk;

  sha512_mmio_rd_responder #(.HC_AFU_ID(ID)) dut (
    .clk(clk), .reset_n(reset_n), .rx_mmio(rx), .tx_mmio(tx),
    .dsm_base(dsm_base), .control(control), .buffers(buffers),
    .busy(busy), .done(done), .start_pulse(start_pulse));

  sha512_mmio_rd_responder #(.HC_AFU_ID(ID), .CYCLES_INIT(64'hFFFF_FFFF_FFFF_FFFD)) dut_sat (
    .clk(clk), .reset_n(reset_n), .rx_mmio(rx), .tx_mmio(tx_sat),
    .dsm_base(dsm_base), .control(control), .buffers(buffers),
    .busy(busy_sat), .done(done), .start_pulse(start_sat));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Cycle counter rule: clear on start, else count busy cycles up to all ones
  always @(posedge clk) begin
    cyc++;
    if (!reset_n)                    mcnt = '0;
    else if (start_pulse)            mcnt = '0;
    else if (busy && mcnt != {64{1'b1}}) mcnt = mcnt + 64'd1;
  end

  // CSR map seen from the host at an 8-byte aligned byte address
  function automatic logic [63:0] model_reg(input int b);
    int i;
    if (b == 'h000) return DFH;
    if (b == 'h008) return ID[63:0];
    if (b == 'h010) return ID[127:64];
    if (b == 'h110) return dsm_base;
    if (b == 'h118) return {32'b0, control};
    if (b == 'h150) return {62'b0, done, busy};
    if (b == 'h158) return mcnt;
    if (b >= 'h120 && b < 'h120 + 16 * HC_BUFFER_SIZE) begin
      i = (b - 'h120) / 16;
      if ((b - 'h120) % 16 == 0) return buffers[i].address;
      return {32'b0, buffers[i].size};
    end
    return '0;
  endfunction

  // Drive a read in the current cycle and queue its predicted response
  task automatic issue(input logic [15:0] a, input logic [1:0] len, input logic [8:0] tid,
                       input bit has_lit, input logic [63:0] lit);
    exp_t e;
    int b;
    logic [63:0] r;
    rx.mmioRdValid = 1'b1;
    rx.hdr.address = a;
    rx.hdr.length  = len;
    rx.hdr.tid     = tid;
    b = int'(a) * 4;
    r = model_reg(b & ~7);
    if (len == 2'b00) r = ((b & 4) != 0) ? {32'b0, r[63:32]} : {32'b0, r[31:0]};
    e.due = cyc + 2; e.tid = tid; e.data = r; e.has_lit = has_lit; e.lit = lit;
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    rx.mmioRdValid = 1'b0;
    rx.mmioWrValid = 1'b0;
    start_pulse    = 1'b0;
  endtask

  // Per-cycle compare: a due response, or an all-zero idle output
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk($sformatf("rsp_valid tid=%0h", e.tid), 128'(tx.mmioRdValid), 128'(1'b1));
      chk($sformatf("rsp_tid tid=%0h", e.tid), 128'(tx.hdr.tid), 128'(e.tid));
      chk($sformatf("rsp_data tid=%0h", e.tid), 128'(tx.data), 128'(e.data));
      if (e.has_lit) chk($sformatf("rsp_literal tid=%0h", e.tid), 128'(tx.data), 128'(e.lit));
    end else begin
      chk("idle_outputs", {tx.mmioRdValid, tx.hdr.tid, tx.data}, '0);
    end
  end

  initial begin
    reset_n = 1'b0; rx = '0; busy = 0; done = 0; start_pulse = 0;
    busy_sat = 0; start_sat = 0;
    dsm_base = '0; control = 32'h8000_0003;
    buffers[0].address = 64'h0000_1000_0000_0040; buffers[0].size = 32'h0000_1234;
    buffers[1].address = 64'h0000_2000_0000_0080; buffers[1].size = 32'h0000_5678;
    buffers[2].address = 64'h0000_3000_0000_00C0; buffers[2].size = 32'hFFFF_0001;
    repeat (3) step();
    reset_n = 1'b1;

    // DFH, dword halves of DSM base, control, buffer registers
    step(); issue(16'h000, 2'b01, 9'h05, 1, DFH);
    step(); dsm_base = 64'hAABB_CCDD_1122_3344;
            issue(16'h044, 2'b00, 9'h01, 1, 64'h1122_3344);
    step(); issue(16'h045, 2'b00, 9'h02, 1, 64'hAABB_CCDD);
    step(); issue(16'h044, 2'b01, 9'h03, 1, 64'hAABB_CCDD_1122_3344);
    // CSR change right after sampling must not leak into the previous read
    step(); dsm_base = 64'h0123_4567_89AB_CDEF;
            issue(16'h044, 2'b01, 9'h04, 1, 64'h0123_4567_89AB_CDEF);
    step(); issue(16'h046, 2'b01, 9'h10, 1, 64'h8000_0003);
    step(); issue(16'h050, 2'b01, 9'h11, 1, 64'h0000_3000_0000_00C0);
    step(); issue(16'h052, 2'b00, 9'h12, 1, 64'hFFFF_0001);
    step(); issue(16'h006, 2'b01, 9'h13, 1, 64'h0);
    step();
    // Back-to-back: ID_L, ID_H, buffers[0].size, out of range
    step(); issue(16'h002, 2'b01, 9'h001, 1, 64'h2222_3333_4444_5555);
    step(); issue(16'h004, 2'b01, 9'h002, 1, 64'hDEAD_BEEF_0000_1111);
    step(); issue(16'h04A, 2'b01, 9'h003, 1, 64'h0000_1234);
    step(); issue(16'h100, 2'b01, 9'h004, 1, 64'h0);
    step(); issue(16'hFFFF, 2'b00, 9'h1FF, 1, 64'h0);
    // Write traffic is ignored: no response
    step(); rx.mmioWrValid = 1'b1; rx.hdr.address = 16'h000;
    step(); step();

    // Busy counter: clear, then 10 busy cycles with reads during the run
    step(); start_pulse = 1'b1;
    step(); busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 4) issue(16'h056, 2'b01, 9'h20, 1, 64'd5);
      if (k == 6) issue(16'h054, 2'b01, 9'h21, 1, 64'h1);
    end
    busy = 1'b0; done = 1'b1;
    step(); issue(16'h056, 2'b01, 9'h22, 1, 64'd10);
    step(); issue(16'h057, 2'b00, 9'h23, 1, 64'h0);
    step(); issue(16'h054, 2'b01, 9'h24, 1, 64'h2);
    // Start together with busy: clear wins, then three more busy cycles
    step(); start_pulse = 1'b1; busy = 1'b1; done = 1'b0;
    repeat (4) step();
    busy = 1'b0;
    issue(16'h056, 2'b01, 9'h25, 1, 64'd3);
    step();

    // Saturation on the preloaded instance
    step(); busy_sat = 1'b1;
    repeat (5) step();
    busy_sat = 1'b0;
    issue(16'h056, 2'b01, 9'h26, 0, '0);
    step(); step();
    chk("sat_valid", 128'(tx_sat.mmioRdValid), 128'(1'b1));
    chk("sat_count", 128'(tx_sat.data), 128'(64'hFFFF_FFFF_FFFF_FFFF));

    // Reset one cycle after a read drops it; first read after reset answered
    step(); issue(16'h000, 2'b01, 9'h30, 0, '0);
    step(); reset_n = 1'b0; q.delete();
    #1;
    chk("reset_outputs", {tx.mmioRdValid, tx.hdr.tid, tx.data}, '0);
    step(); step();
    reset_n = 1'b1;
    issue(16'h002, 2'b01, 9'h31, 1, 64'h2222_3333_4444_5555);
    step(); issue(16'h056, 2'b01, 9'h32, 1, 64'd0);
    repeat (4) step();
    chk("all_responses_seen", 128'(q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
